icache_tag_wr_ctrl: RTL and testbench

//  Sole owner of the icache tag array write port. Sequences two write sources:
//  - line refills from the miss handler, with victim-way selection;
//  - full-array invalidation sweeps (fence.i / flush).

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_victim_sel.sv | 23 ++
 rtl/icache_tag_wr_ctrl.sv | 174 +++++++++++++++++
 tb/tb_icache_tag_wr_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry for the icache tag-array write controller.
// Geometry is fixed here; all icache tag-path blocks import this package.
package icache_pkg;

  localparam int unsigned NUM_WAYS            = 4;
  localparam int unsigned NUM_BANKS           = 4;
  localparam int unsigned SETS_PER_BANK_WIDTH = 8;
  localparam int unsigned TAG_WIDTH           = 20;
  localparam int unsigned VALID_WIDTH         = 1;

  localparam int unsigned BANK_SEL_W  = $clog2(NUM_BANKS);
  localparam int unsigned WAY_IDX_W   = $clog2(NUM_WAYS);
  localparam int unsigned FLUSH_CNT_W = BANK_SEL_W + SETS_PER_BANK_WIDTH;

  // Sweep counter {bank, set}: set is the fast-moving field.
  typedef logic [FLUSH_CNT_W-1:0] flush_cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StFlush
  } tag_wr_state_e;

endpackage

// File: rtl/icache_victim_sel.sv
// Combinational refill victim choice: lowest-index invalid way, else the
// round-robin pointer supplied by the parent.
module icache_victim_sel
  import icache_pkg::*;
(
  input  logic [NUM_WAYS-1:0]  way_valid_i,
  input  logic [WAY_IDX_W-1:0] rr_i,
  output logic [WAY_IDX_W-1:0] victim_o,
  output logic                 all_valid_o
);

  always_comb begin
    all_valid_o = &way_valid_i;
    victim_o    = rr_i;
    // Scan downwards so the lowest invalid way is the last to overwrite.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid_i[w]) begin
        victim_o = WAY_IDX_W'(w);
      end
    end
  end

endmodule

// File: rtl/icache_tag_wr_ctrl.sv
// Sole owner of the icache tag-array write port: serialises line refills and
// invalidate-all sweeps. Define ICACHE_TAG_RESET_SWEEP_EN to sweep after reset.
module icache_tag_wr_ctrl
  import icache_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_req_i,
  output logic                           flush_done_o,
  output logic                           busy_o,
  input  logic                           refill_valid_i,
  output logic                           refill_ready_o,
  input  logic [SETS_PER_BANK_WIDTH-1:0] refill_bank_addr_i,
  input  logic [BANK_SEL_W-1:0]          refill_bank_sel_i,
  input  logic [TAG_WIDTH-1:0]           refill_tag_i,
  input  logic [NUM_WAYS-1:0]            refill_way_valid_i,
  output logic                           refill_done_o,
  output logic [WAY_IDX_W-1:0]           refill_way_o,
  output logic [SETS_PER_BANK_WIDTH-1:0] w_bank_addr_o,
  output logic [BANK_SEL_W-1:0]          w_bank_sel_o,
  output logic [NUM_WAYS-1:0]            we_way_mask_o,
  output logic [TAG_WIDTH-1:0]           wdata_tag_o,
  output logic [VALID_WIDTH-1:0]         wdata_valid_o
);

`ifdef ICACHE_TAG_RESET_SWEEP_EN
  localparam logic FlushPendRst = 1'b1;
`else
  localparam logic FlushPendRst = 1'b0;
`endif

  tag_wr_state_e                  state_q, state_d;
  flush_cnt_t                     cnt_q, cnt_d;
  logic                           flush_pend_q, flush_pend_d;
  logic [WAY_IDX_W-1:0]           rr_q, rr_d;

  logic [SETS_PER_BANK_WIDTH-1:0] ref_addr_q, ref_addr_d;
  logic [BANK_SEL_W-1:0]          ref_bank_q, ref_bank_d;
  logic [TAG_WIDTH-1:0]           ref_tag_q, ref_tag_d;
  logic [WAY_IDX_W-1:0]           ref_way_q, ref_way_d;

  logic [SETS_PER_BANK_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [BANK_SEL_W-1:0]          w_sel_q, w_sel_d;
  logic [NUM_WAYS-1:0]            we_mask_q, we_mask_d;
  logic [TAG_WIDTH-1:0]           w_tag_q, w_tag_d;
  logic [VALID_WIDTH-1:0]         w_valid_q, w_valid_d;
  logic                           refill_done_q, refill_done_d;
  logic [WAY_IDX_W-1:0]           refill_way_q, refill_way_d;
  logic                           flush_done_q, flush_done_d;

  logic [WAY_IDX_W-1:0]           victim;
  logic                           all_valid;

  icache_victim_sel u_victim_sel (
    .way_valid_i (refill_way_valid_i),
    .rr_i        (rr_q),
    .victim_o    (victim),
    .all_valid_o (all_valid)
  );

  assign refill_ready_o = (state_q == StIdle) & ~flush_pend_q & ~flush_req_i;
  assign busy_o         = (state_q != StIdle);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_pend_d  = flush_pend_q;
    rr_d          = rr_q;
    ref_addr_d    = ref_addr_q;
    ref_bank_d    = ref_bank_q;
    ref_tag_d     = ref_tag_q;
    ref_way_d     = ref_way_q;
    w_addr_d      = w_addr_q;
    w_sel_d       = w_sel_q;
    w_tag_d       = w_tag_q;
    w_valid_d     = w_valid_q;
    refill_way_d  = refill_way_q;
    we_mask_d     = '0;
    refill_done_d = 1'b0;
    flush_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush_pend_q || flush_req_i) begin
          state_d      = StFlush;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else if (refill_valid_i) begin
          state_d    = StRefill;
          ref_addr_d = refill_bank_addr_i;
          ref_bank_d = refill_bank_sel_i;
          ref_tag_d  = refill_tag_i;
          ref_way_d  = victim;
          if (all_valid) begin
            rr_d = (rr_q == WAY_IDX_W'(NUM_WAYS - 1)) ? '0 : rr_q + WAY_IDX_W'(1);
          end
        end
      end
      StRefill: begin
        if (flush_req_i) flush_pend_d = 1'b1;
        w_addr_d      = ref_addr_q;
        w_sel_d       = ref_bank_q;
        w_tag_d       = ref_tag_q;
        w_valid_d     = '1;
        we_mask_d     = NUM_WAYS'(1) << ref_way_q;
        refill_way_d  = ref_way_q;
        refill_done_d = 1'b1;
        state_d       = StIdle;
      end
      StFlush: begin
        // Requests arriving mid-sweep are covered by this sweep and dropped.
        w_addr_d  = cnt_q[SETS_PER_BANK_WIDTH-1:0];
        w_sel_d   = cnt_q[FLUSH_CNT_W-1 -: BANK_SEL_W];
        w_tag_d   = '0;
        w_valid_d = '0;
        we_mask_d = '1;
        cnt_d     = cnt_q + flush_cnt_t'(1);
        if (&cnt_q) begin
          flush_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      flush_pend_q  <= FlushPendRst;
      rr_q          <= '0;
      ref_addr_q    <= '0;
      ref_bank_q    <= '0;
      ref_tag_q     <= '0;
      ref_way_q     <= '0;
      w_addr_q      <= '0;
      w_sel_q       <= '0;
      we_mask_q     <= '0;
      w_tag_q       <= '0;
      w_valid_q     <= '0;
      refill_done_q <= 1'b0;
      refill_way_q  <= '0;
      flush_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_pend_q  <= flush_pend_d;
      rr_q          <= rr_d;
      ref_addr_q    <= ref_addr_d;
      ref_bank_q    <= ref_bank_d;
      ref_tag_q     <= ref_tag_d;
      ref_way_q     <= ref_way_d;
      w_addr_q      <= w_addr_d;
      w_sel_q       <= w_sel_d;
      we_mask_q     <= we_mask_d;
      w_tag_q       <= w_tag_d;
      w_valid_q     <= w_valid_d;
      refill_done_q <= refill_done_d;
      refill_way_q  <= refill_way_d;
      flush_done_q  <= flush_done_d;
    end
  end

  assign w_bank_addr_o = w_addr_q;
  assign w_bank_sel_o  = w_sel_q;
  assign we_way_mask_o = we_mask_q;
  assign wdata_tag_o   = w_tag_q;
  assign wdata_valid_o = w_valid_q;
  assign refill_done_o = refill_done_q;
  assign refill_way_o  = refill_way_q;
  assign flush_done_o  = flush_done_q;

endmodule

// File: tb/tb_icache_tag_wr_ctrl.sv
// Bench for icache_tag_wr_ctrl: expected-write scoreboard driven by a
// transaction-level model, a directed vector table and randomized refills.
module tb_icache_tag_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_req_i = 1'b0;
  logic        refill_valid_i = 1'b0;
  logic [7:0]  refill_bank_addr_i = '0;
  logic [1:0]  refill_bank_sel_i = '0;
  logic [19:0] refill_tag_i = '0;
  logic [3:0]  refill_way_valid_i = '0;
  logic        flush_done_o, busy_o, refill_ready_o, refill_done_o;
  logic [1:0]  refill_way_o, w_bank_sel_o;
  logic [7:0]  w_bank_addr_o;
  logic [3:0]  we_way_mask_o;
  logic [19:0] wdata_tag_o;
  logic [0:0]  wdata_valid_o;

  icache_tag_wr_ctrl dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_req_i        (flush_req_i),
    .flush_done_o       (flush_done_o),
    .busy_o             (busy_o),
    .refill_valid_i     (refill_valid_i),
    .refill_ready_o     (refill_ready_o),
    .refill_bank_addr_i (refill_bank_addr_i),
    .refill_bank_sel_i  (refill_bank_sel_i),
    .refill_tag_i       (refill_tag_i),
    .refill_way_valid_i (refill_way_valid_i),
    .refill_done_o      (refill_done_o),
    .refill_way_o       (refill_way_o),
    .w_bank_addr_o      (w_bank_addr_o),
    .w_bank_sel_o       (w_bank_sel_o),
    .we_way_mask_o      (we_way_mask_o),
    .wdata_tag_o        (wdata_tag_o),
    .wdata_valid_o      (wdata_valid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic [1:0]  bank;
    logic [3:0]  mask;
    logic [19:0] tag;
    logic        valid;
    logic        rdone;
    logic [1:0]  way;
    logic        fdone;
  } wr_t;

  typedef struct {
    int  due;
    wr_t w;
  } exp_t;

  typedef struct {
    logic [3:0]  vv;
    logic [1:0]  bank;
    logic [7:0]  addr;
    logic [19:0] tag;
    logic [1:0]  way;
    logic [3:0]  mask;
  } vec_t;

  exp_t       q[$];
  vec_t       tv[10];
  int         total = 0, bad = 0, cyc_n = 0;
  int         hs_cyc = -1, fd_cyc = -1;
  logic [1:0] m_rr = '0;
  bit         hs_seen, rd_seen;
  logic [1:0] rd_way;
  logic [3:0] rd_mask;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Victim rule: lowest invalid way, else round-robin pointer which then advances.
  function automatic logic [1:0] model_victim(input logic [3:0] vv);
    logic [1:0] v;
    for (int w = 0; w < 4; w++) begin
      if (!vv[w]) return 2'(w);
    end
    v    = m_rr;
    m_rr = 2'((int'(m_rr) + 1) % 4);
    return v;
  endfunction

  function automatic logic [39:0] all_outs();
    return {we_way_mask_o, w_bank_addr_o, w_bank_sel_o, wdata_tag_o, wdata_valid_o,
            refill_done_o, refill_way_o, flush_done_o, busy_o};
  endfunction

  // One clock: sample at negedge, score writes, then step to just past posedge.
  task automatic cyc();
    wr_t        act;
    exp_t       e;
    logic [1:0] v;
    @(negedge clk);
    hs_seen = refill_valid_i && refill_ready_o && rst_ni;
    while (q.size() > 0 && q[0].due < cyc_n) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_write: got none want %h at cycle %0d", e.w, e.due);
    end
    if (we_way_mask_o != 0 || refill_done_o || flush_done_o) begin
      act = '{w_bank_addr_o, w_bank_sel_o, we_way_mask_o, wdata_tag_o, wdata_valid_o,
              refill_done_o, (refill_done_o ? refill_way_o : 2'b00), flush_done_o};
      if (q.size() == 0 || q[0].due != cyc_n) begin
        total++;
        bad++;
        $display("FAIL spurious_write: got %h want none at cycle %0d", act, cyc_n);
      end else begin
        e = q.pop_front();
        chk("write", 64'(act), 64'(e.w));
      end
    end
    if (refill_done_o) begin
      rd_seen = 1'b1;
      rd_way  = refill_way_o;
      rd_mask = we_way_mask_o;
    end
    if (flush_done_o) fd_cyc = cyc_n;
    if (hs_seen) begin
      hs_cyc = cyc_n;
      v = model_victim(refill_way_valid_i);
      q.push_back('{due: cyc_n + 2,
                    w: '{refill_bank_addr_i, refill_bank_sel_i, 4'b0001 << v, refill_tag_i,
                         1'b1, 1'b1, v, 1'b0}});
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic push_flush(input int start);
    for (int k = 0; k < 1024; k++) begin
      q.push_back('{due: start + 2 + k,
                    w: '{8'(k % 256), 2'(k / 256), 4'hF, 20'h0, 1'b0, 1'b0, 2'b00, (k == 1023)}});
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() > 0 && n < limit) begin
      cyc();
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_refill(input logic [3:0] vv, input logic [1:0] b, input logic [7:0] a,
                           input logic [19:0] t);
    int n = 0;
    refill_way_valid_i = vv;
    refill_bank_sel_i  = b;
    refill_bank_addr_i = a;
    refill_tag_i       = t;
    refill_valid_i     = 1'b1;
    rd_seen            = 1'b0;
    do begin
      cyc();
      n++;
    end while (!hs_seen && n < 2000);
    refill_valid_i = 1'b0;
    if (!hs_seen) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: got no ready want ready");
    end
    n = 0;
    while (!rd_seen && n < 8) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int start;
    tv[0] = '{4'b1011, 2'd2, 8'h5A, 20'hABCDE, 2'd2, 4'b0100};
    tv[1] = '{4'hF,    2'd0, 8'h01, 20'h11111, 2'd0, 4'b0001};
    tv[2] = '{4'hF,    2'd1, 8'h02, 20'h22222, 2'd1, 4'b0010};
    tv[3] = '{4'hF,    2'd2, 8'h03, 20'h33333, 2'd2, 4'b0100};
    tv[4] = '{4'hF,    2'd3, 8'h04, 20'h44444, 2'd3, 4'b1000};
    tv[5] = '{4'hF,    2'd0, 8'hFF, 20'hFFFFF, 2'd0, 4'b0001};
    tv[6] = '{4'b1110, 2'd1, 8'h80, 20'h0F0F0, 2'd0, 4'b0001};
    tv[7] = '{4'hF,    2'd3, 8'h00, 20'h12345, 2'd1, 4'b0010};
    tv[8] = '{4'b0111, 2'd2, 8'h7E, 20'hC0FFE, 2'd3, 4'b1000};
    tv[9] = '{4'hF,    2'd1, 8'hA5, 20'h5A5A5, 2'd2, 4'b0100};

    #2;
    chk("reset_outputs", 64'(all_outs()), 64'h0);
    cyc();
    cyc();
    rst_ni = 1'b1;
`ifdef ICACHE_TAG_RESET_SWEEP_EN
    chk("reset_sweep_ready", 64'(refill_ready_o), 64'h0);
    push_flush(cyc_n);
    drain(1100);
`endif
    cyc();
    chk("idle_ready", 64'({busy_o, refill_ready_o}), 64'b01);

    // Single-cycle flush pulse: full 1024-write sweep.
    flush_req_i = 1'b1;
    start = cyc_n;
    push_flush(start);
    cyc();
    flush_req_i = 1'b0;
    chk("flush_busy", 64'({busy_o, refill_ready_o}), 64'b10);
    drain(1100);
    chk("flush_done_cycle", 64'(fd_cyc), 64'(start + 2 + 1023));
    chk("post_flush_idle", 64'({busy_o, refill_ready_o}), 64'b01);

    for (int i = 0; i < 10; i++) begin
      do_refill(tv[i].vv, tv[i].bank, tv[i].addr, tv[i].tag);
      chk($sformatf("vec%0d_way", i), 64'(rd_way), 64'(tv[i].way));
      chk($sformatf("vec%0d_mask", i), 64'(rd_mask), 64'(tv[i].mask));
    end

    // Flush and refill together: flush wins, refill taken as the sweep ends.
    refill_way_valid_i = 4'hF;
    refill_bank_sel_i  = 2'd1;
    refill_bank_addr_i = 8'h33;
    refill_tag_i       = 20'h12345;
    refill_valid_i     = 1'b1;
    flush_req_i        = 1'b1;
    #1;
    chk("collision_ready", 64'(refill_ready_o), 64'h0);
    start = cyc_n;
    push_flush(start);
    cyc();
    flush_req_i = 1'b0;
    for (int n = 0; n < 1200 && !hs_seen; n++) cyc();
    refill_valid_i = 1'b0;
    chk("collision_accept_cycle", 64'(hs_cyc), 64'(start + 2 + 1023));
    drain(10);

    for (int r = 0; r < 150; r++) begin
      do_refill(($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom), 2'($urandom),
                8'($urandom), 20'($urandom));
      repeat ($urandom_range(0, 2)) cyc();
    end
    drain(10);

    // Async reset in the middle of a sweep.
    flush_req_i = 1'b1;
    start = cyc_n;
    push_flush(start);
    cyc();
    flush_req_i = 1'b0;
    while (cyc_n < start + 2 + 500) cyc();
    rst_ni = 1'b0;
    #1;
    chk("reset_mid_sweep", 64'(all_outs()), 64'h0);
    q.delete();
    m_rr   = '0;
    fd_cyc = -1;
    cyc();
    cyc();
    rst_ni = 1'b1;
`ifdef ICACHE_TAG_RESET_SWEEP_EN
    start = cyc_n;
    push_flush(start);
    drain(1100);
    chk("resweep_done_cycle", 64'(fd_cyc), 64'(start + 2 + 1023));
`else
    repeat (1100) cyc();
    chk("no_done_after_reset", 64'(fd_cyc), 64'(-1));
    chk("stays_idle", 64'({busy_o, refill_ready_o}), 64'b01);
`endif
    do_refill(4'hF, 2'd0, 8'h10, 20'hBEEF0);
    chk("rr_after_reset", 64'(rd_way), 64'h0);
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
